// File: rtl/seq_pkg.sv
// seq_pkg: shared definitions for the 10010 serial pattern detector.
//   - state_e : 3-bit state code = length of the longest received suffix
//               that is also a prefix of PATTERN (5 means full match).
//   - PATTERN / PAT_LEN : the fixed pattern and its length.
//   - sr_to_state : maps the last five received bits to the state code.
package seq_pkg;

  typedef enum logic [2:0] {
    S0 = 3'd0,  // idle
    S1 = 3'd1,  // "1"
    S2 = 3'd2,  // "10"
    S3 = 3'd3,  // "100"
    S4 = 3'd4,  // "1001"
    S5 = 3'd5   // "10010"
  } state_e;

  localparam logic [4:0] PATTERN = 5'b10010;
  localparam int         PAT_LEN = 5;

  // Longest-match-first decode of the shift register: the k newest bits are
  // compared against the first k bits of the pattern.
  function automatic state_e sr_to_state(input logic [4:0] sr);
    state_e st;
    if (sr == PATTERN) begin
      st = S5;
    end else if (sr[3:0] == PATTERN[4:1]) begin
      st = S4;
    end else if (sr[2:0] == PATTERN[4:2]) begin
      st = S3;
    end else if (sr[1:0] == PATTERN[4:3]) begin
      st = S2;
    end else if (sr[0] == PATTERN[4]) begin
      st = S1;
    end else begin
      st = S0;
    end
    return st;
  endfunction

endpackage

// File: rtl/seq_reg.sv
// seq_reg: shift-register implementation of the 10010 detector.
// Ports:
//   clk   - rising-edge clock
//   in    - serial data bit (shifted into the LSB)
//   reset - synchronous active-low reset
//   out   - registered match flag (high when the last five bits are 10010)
//   state - registered state code decoded from the last five bits
module seq_reg
  import seq_pkg::*;
(
  input  logic       clk,
  input  logic       in,
  input  logic       reset,
  output logic       out,
  output logic [2:0] state
);

  logic [4:0] sr_q, sr_d;
  logic [2:0] state_q, state_d;
  logic       out_q, out_d;

  // Shift in the new bit and decode from the post-shift value so the
  // registered outputs line up cycle-for-cycle with the state machine.
  always_comb begin
    sr_d    = {sr_q[3:0], in};
    state_d = sr_to_state(sr_d);
    out_d   = (sr_d == PATTERN);
  end

  // Shift register and output registers with synchronous active-low reset.
  // Zero fill after reset cannot fake a partial match: the pattern starts with 1.
  always_ff @(posedge clk) begin
    if (!reset) begin
      sr_q    <= 5'b00000;
      state_q <= 3'd0;
      out_q   <= 1'b0;
    end else begin
      sr_q    <= sr_d;
      state_q <= state_d;
      out_q   <= out_d;
    end
  end

  assign out   = out_q;
  assign state = state_q;

endmodule

// File: rtl/seq_sfm.sv
// seq_sfm: explicit state-machine implementation of the 10010 detector.
// Ports:
//   clk   - rising-edge clock
//   in    - serial data bit
//   reset - synchronous active-low reset
//   out   - registered match flag (high while state is S5)
//   state - registered current state code
module seq_sfm
  import seq_pkg::*;
(
  input  logic       clk,
  input  logic       in,
  input  logic       reset,
  output logic       out,
  output logic [2:0] state
);

  state_e state_q, state_d;
  logic   out_q, out_d;

  // Next-state logic; S5 on a 0 falls back to S3 so overlapping matches
  // ("10010" then "010") are found.
  always_comb begin
    state_d = S0;
    case (state_q)
      S0:      state_d = in ? S1 : S0;
      S1:      state_d = in ? S1 : S2;
      S2:      state_d = in ? S1 : S3;
      S3:      state_d = in ? S4 : S0;
      S4:      state_d = in ? S1 : S5;
      S5:      state_d = in ? S1 : S3;
      default: state_d = S0;  // unused codes recover to idle
    endcase
    // Output is registered alongside the state, so it equals (state == S5).
    out_d = (state_d == S5);
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= S0;
      out_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      out_q   <= out_d;
    end
  end

  assign out   = out_q;
  assign state = state_q;

endmodule

// File: rtl/seq_detect.sv
// seq_detect: detects every (overlapping) occurrence of 10010 on a serial
// input using two independent implementations running side by side.
// Ports:
//   clk       - rising-edge clock
//   reset     - synchronous active-low reset
//   in        - serial data, one bit per rising edge
//   out_sfm   - match flag, state-machine implementation
//   state_sfm - state code, state-machine implementation
//   out_reg   - match flag, shift-register implementation
//   state_reg - state code, shift-register implementation
module seq_detect
  import seq_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       in,
  output logic       out_sfm,
  output logic [2:0] state_sfm,
  output logic       out_reg,
  output logic [2:0] state_reg
);

  seq_sfm u_sfm (
    .clk   (clk),
    .in    (in),
    .reset (reset),
    .out   (out_sfm),
    .state (state_sfm)
  );

  seq_reg u_reg (
    .clk   (clk),
    .in    (in),
    .reset (reset),
    .out   (out_reg),
    .state (state_reg)
  );

endmodule

// File: tb/tb_seq_detect.sv
// Scoreboard bench for seq_detect: a driver applies bits on the falling edge
// and queues the expected post-edge response; a monitor pops and compares
// both implementations just after every rising edge.
module tb_seq_detect;

  logic       clk = 1'b0;
  logic       reset_s = 1'b0;
  logic       in_s = 1'b0;
  logic       out_sfm, out_reg;
  logic [2:0] state_sfm, state_reg;

  seq_detect dut (
    .clk       (clk),
    .reset     (reset_s),
    .in        (in_s),
    .out_sfm   (out_sfm),
    .state_sfm (state_sfm),
    .out_reg   (out_reg),
    .state_reg (state_reg)
  );

  always #5 clk = ~clk;

  typedef struct {
    int st;
    int o;
  } exp_t;

  exp_t exp_q[$];
  int   hist[$];          // bits received since reset (newest at back, at most 5)
  int   pat_bits[5] = '{1, 0, 0, 1, 0};
  int   errors = 0;
  int   checks = 0;

  // Reference: longest suffix of the received history equal to a pattern prefix.
  function automatic int model_state();
    for (int k = 5; k >= 1; k--) begin
      if (hist.size() >= k) begin
        bit ok = 1'b1;
        for (int j = 0; j < k; j++) begin
          if (hist[hist.size() - k + j] != pat_bits[j]) ok = 1'b0;
        end
        if (ok) return k;
      end
    end
    return 0;
  endfunction

  task automatic chk(input string name, input int act, input int expv);
    checks++;
    if (act != expv) begin
      errors++;
      $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, expv);
    end
  endtask

  // Drive one bit (and reset level) for the next rising edge and queue the
  // expected response. forced >= 0 supplies a hand-derived state instead.
  task automatic drive(input int b, input int r, input int forced);
    exp_t e;
    int   st;
    @(negedge clk);
    in_s    = b[0];
    reset_s = r[0];
    if (r == 0) begin
      hist.delete();
    end else begin
      hist.push_back(b);
      if (hist.size() > 5) void'(hist.pop_front());
    end
    st   = (forced >= 0) ? forced : model_state();
    e.st = st;
    e.o  = (st == 5) ? 1 : 0;
    exp_q.push_back(e);
  endtask

  // Monitor: compare both implementations against the queued expectation.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("state_sfm", int'(state_sfm), e.st);
        chk("out_sfm",   int'(out_sfm),   e.o);
        chk("state_reg", int'(state_reg), e.st);
        chk("out_reg",   int'(out_reg),   e.o);
      end
    end
  end

  int ref_bits[17] = '{1,0,1,1,1,0,0,1,0,0,1,1,1,0,0,1,0};
  int ref_st[19]   = '{1,2,1,1,1,2,3,4,5,3,4,1,1,2,3,4,5,3,0};
  int ovl_bits[8]  = '{1,0,0,1,0,0,1,0};
  int nm1_bits[6]  = '{1,0,0,0,1,0};
  int nm2_bits[5]  = '{1,0,0,1,1};
  int mid_bits[4]  = '{1,0,0,1};

  initial begin
    // Reset held for two edges with the input toggling.
    drive(1, 0, -1);
    drive(0, 0, -1);

    // Reference stream with hand-derived state sequence (plus two trailing 0s).
    for (int i = 0; i < 19; i++) drive((i < 17) ? ref_bits[i] : 0, 1, ref_st[i]);

    // Overlap.
    drive(1, 0, -1);
    for (int i = 0; i < 8; i++) drive(ovl_bits[i], 1, (i == 5) ? 3 : -1);

    // Near misses.
    drive(0, 0, -1);
    for (int i = 0; i < 6; i++) drive(nm1_bits[i], 1, (i == 3) ? 0 : -1);
    drive(0, 0, -1);
    for (int i = 0; i < 5; i++) drive(nm2_bits[i], 1, (i == 4) ? 1 : -1);

    // Reset in the middle of a pattern, then the would-be completing 0.
    drive(0, 0, -1);
    for (int i = 0; i < 4; i++) drive(mid_bits[i], 1, -1);
    drive(0, 0, 0);
    drive(0, 1, 0);

    // Random bits with occasional reset pulses.
    for (int i = 0; i < 10000; i++) begin
      drive(int'($urandom_range(1, 0)), ($urandom_range(63, 0) == 0) ? 0 : 1, -1);
    end

    // Let the monitor drain the queue, bounded.
    for (int i = 0; i < 20 && exp_q.size() > 0; i++) @(posedge clk);
    #3;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/seq_detect.md
# seq_detect

Serial bit-stream pattern detector for the FSM-learning area. It flags every occurrence of the 5-bit pattern 1-0-0-1-0 on a 1-bit input, with overlapping occurrences allowed. The block contains two independent, cycle-equivalent implementations: an explicit state machine and a shift-register matcher. Both run side by side so each cross-checks the other.

## Interface
- Parameters: none. The pattern 5'b10010 is a fixed constant.
- `clk`  in  1  Rising-edge clock; the only clock.
- `reset`  in  1  Reset. One clock; reset is synchronous and active-low.
- `in`  in  1  Serial data, one bit sampled per rising edge.
- `out_sfm`  out  1  Match flag from the state-machine implementation.
- `state_sfm`  out  3  Current state code from the state-machine implementation.
- `out_reg`  out  1  Match flag from the shift-register implementation.
- `state_reg`  out  3  Equivalent state code derived by the shift-register implementation.

## Operation
- The state code is the length of the longest suffix of the bits received since reset that equals a prefix of 10010. Value 5 means a full match.
- States:
  - S0=0: idle.
  - S1=1: "1".
  - S2=2: "10".
  - S3=3: "100".
  - S4=4: "1001".
  - S5=5: "10010".
  - Codes 6 and 7 are unused and recover to S0 on the next edge.
- State-machine transitions, written as in=0 / in=1:
  - S0 → S0 / S1
  - S1 → S2 / S1
  - S2 → S3 / S1
  - S3 → S0 / S4
  - S4 → S5 / S1
  - S5 → S3 / S1 (overlap)
- Moore output: out = (state == S5). There is no combinational path from `in` to any output.
- Shift-register version:
  - A 5-bit register sr shifts `in` into the LSB each edge: sr <= {sr[3:0], in}.
  - state_reg priority decode:
    - sr == 10010 → 5
    - else sr[3:0] == 1001 → 4
    - else sr[2:0] == 100 → 3
    - else sr[1:0] == 10 → 2
    - else sr[0] == 1 → 1
    - else 0
  - out_reg = (sr == 10010).
- Invariant: out_sfm == out_reg and state_sfm == state_reg on every cycle after reset.

## Timing
- Reset (reset low at a rising edge):
  - State register goes to S0 and sr goes to 5'b00000.
  - All outputs read 0 from the following cycle onward.
  - Reset overrides `in` and takes effect immediately, including mid-pattern.
- Reset zeros cannot produce a false partial match, because the pattern starts with 1.
- Latency: the output rises in the cycle after the rising edge that samples the final 0 of the pattern. It stays high exactly one cycle unless the next bit continues an overlapping match.
- Overlap: the input 10010010 produces two one-cycle pulses, after the 5th and the 8th bits.
- Minimum spacing between pulses: 3 cycles.
- `in` must be stable around each rising edge. The bench changes it mid-period.

## Structure
- Shared package `seq_pkg`:
  - 3-bit state codes S0..S5.
  - PATTERN = 5'b10010.
  - PAT_LEN = 5.
- Top `seq_detect` instantiates two sub-modules with identical port lists (clk, in, reset, out, state[2:0]):
  - `seq_sfm`: two-process FSM; state register plus next-state logic.
  - `seq_reg`: shift register plus priority decoder.

## Test plan
- Reset: hold reset=0 for 2 edges with in toggling → both state outputs 0, both out 0.
- Reference stream: release reset, then drive 1,0,1,1,1,0,0,1,0,0,1,1,1,0,0,1,0 followed by 0s, one bit per edge.
  - out pulses for exactly one cycle after bit 9 and after bit 17; it is 0 everywhere else.
  - state_sfm sequence across the stream: 1,2,1,1,1,2,3,4,5,3,4,1,1,2,3,4,5,3,0.
- Overlap: drive 1,0,0,1,0,0,1,0 → pulses after bits 5 and 8; state is 3 after bit 6.
- Near misses:
  - 1,0,0,0,1,0 → no pulse; state drops to 0 after the 4th bit.
  - 1,0,0,1,1 → no pulse; state is 1 after the 5th bit.
- Mid-pattern reset: drive 1,0,0,1, assert reset for one edge, then drive 0 → no pulse; state is 0.
- Equivalence: 10,000 random bits with random reset pulses → out_sfm == out_reg and state_sfm == state_reg on every cycle.
